// File: rtl/num_to_str_pkg.sv
// num_to_str_pkg: shared types and constants for the number-to-ASCII converter.
//   state_t     : converter FSM states
//   ASCII_ZERO  : ASCII "0", base for digit characters
//   ASCII_MINUS : ASCII "-", sign prefix in signed builds
//   IDX_MAX     : index of the most significant decimal digit (10^9)
//   POW10_TABLE : 10^0 .. 10^9 as 32-bit unsigned values, indexed by digit index
package num_to_str_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SEND,
    TERM
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [3:0] IDX_MAX     = 4'd9;

  // Element [i] holds 10^i; the concatenation lists the highest index first.
  localparam logic [9:0][31:0] POW10_TABLE = {
    32'd1000000000,
    32'd100000000,
    32'd10000000,
    32'd1000000,
    32'd100000,
    32'd10000,
    32'd1000,
    32'd100,
    32'd10,
    32'd1
  };

endpackage

// File: rtl/num_to_str_pow10.sv
// num_to_str_pow10: combinational power-of-ten lookup.
//   idx : decimal digit index 0..9
//   pow : 10^idx (zero for indices above 9, which the converter never produces)
module num_to_str_pow10
  import num_to_str_pkg::*;
(
  input  logic [3:0]  idx,
  output logic [31:0] pow
);

  always_comb begin
    pow = '0;
    if (idx <= IDX_MAX) begin
      pow = POW10_TABLE[idx];
    end
  end

endmodule

// File: rtl/num_to_str.sv
// num_to_str: converts a 32-bit number to decimal ASCII, one character per
// handshake, followed by a terminator byte. Digits are found by repeated
// subtraction of 10^idx, most significant first; leading zeros are skipped.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   n_dtm  : number to convert, accepted when n_vld && n_rdy
//   n_vld  : n_dtm valid
//   n_rdy  : converter idle and able to accept a number
//   s_dtm  : ASCII character out
//   s_vld  : s_dtm valid
//   s_rdy  : downstream accepts s_dtm
// Parameter TERM_CHAR: byte emitted after the last digit (default newline).
// Build option NUM_TO_STR_SIGNED_EN: treat n_dtm as two's complement and
// prefix negative numbers with "-".
module num_to_str
  import num_to_str_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] n_dtm,
  input  logic        n_vld,
  output logic        n_rdy,
  output logic [7:0]  s_dtm,
  output logic        s_vld,
  input  logic        s_rdy
);

  state_t      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  digit_q, digit_d;
  logic        started_q, started_d;
  logic [7:0]  s_dtm_q, s_dtm_d;
  logic        sign_q, sign_d;     // "-" currently being sent, idx not yet consumed

  logic [31:0] pow;
  logic [31:0] cap_rem;
  logic        cap_neg;

  num_to_str_pow10 u_pow10 (
    .idx (idx_q),
    .pow (pow)
  );

`ifdef NUM_TO_STR_SIGNED_EN
  // Magnitude as unsigned: 0x80000000 negates to itself, which reads as 2^31.
  assign cap_neg = n_dtm[31];
  assign cap_rem = n_dtm[31] ? (~n_dtm + 32'd1) : n_dtm;
`else
  assign cap_neg = 1'b0;
  assign cap_rem = n_dtm;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      idx_q     <= IDX_MAX;
      digit_q   <= '0;
      started_q <= 1'b0;
      s_dtm_q   <= '0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      digit_q   <= digit_d;
      started_q <= started_d;
      s_dtm_q   <= s_dtm_d;
      sign_q    <= sign_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    digit_d   = digit_q;
    started_d = started_q;
    s_dtm_d   = s_dtm_q;
    sign_d    = sign_q;

    unique case (state_q)
      IDLE: begin
        if (n_vld) begin
          rem_d     = cap_rem;
          idx_d     = IDX_MAX;
          digit_d   = '0;
          started_d = 1'b0;
          if (cap_neg) begin
            sign_d  = 1'b1;
            s_dtm_d = ASCII_MINUS;
            state_d = SEND;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (rem_q >= pow) begin
          rem_d   = rem_q - pow;
          digit_d = digit_q + 4'd1;
        end else if (digit_q == 4'd0 && !started_q && idx_q != 4'd0) begin
          idx_d   = idx_q - 4'd1;
          digit_d = '0;
        end else begin
          s_dtm_d   = ASCII_ZERO + {4'h0, digit_q};
          started_d = 1'b1;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (s_rdy) begin
          if (sign_q) begin
            // Sign sent: start the magnitude at the same (top) digit index.
            sign_d  = 1'b0;
            state_d = CALC;
          end else if (idx_q != 4'd0) begin
            idx_d   = idx_q - 4'd1;
            digit_d = '0;
            state_d = CALC;
          end else begin
            s_dtm_d = TERM_CHAR;
            state_d = TERM;
          end
        end
      end

      TERM: begin
        if (s_rdy) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign n_rdy = (state_q == IDLE);
  assign s_vld = (state_q == SEND) || (state_q == TERM);
  assign s_dtm = s_dtm_q;

endmodule

// File: tb/tb_num_to_str.sv
module tb_num_to_str;

  logic        clk;
  logic        rst_n;
  logic [31:0] n_dtm;
  logic        n_vld;
  logic        n_rdy;
  logic [7:0]  s_dtm;
  logic        s_vld;
  logic        s_rdy;

  num_to_str #(.TERM_CHAR(8'h0A)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .n_dtm (n_dtm),
    .n_vld (n_vld),
    .n_rdy (n_rdy),
    .s_dtm (s_dtm),
    .s_vld (s_vld),
    .s_rdy (s_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] n;
    logic [95:0] s;     // expected characters, right-aligned
    int unsigned len;
  } vec_t;

`ifdef NUM_TO_STR_SIGNED_EN
  localparam int NV = 6;
`else
  localparam int NV = 7;
`endif
  vec_t vecs [NV];

  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic stall_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_dtm = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_str(input logic [95:0] s, input int unsigned len);
    for (int i = int'(len) - 1; i >= 0; i--) exp_q.push_back(s[i*8 +: 8]);
    exp_q.push_back(8'h0A);
  endtask

  // Offer a number as soon as the converter is idle; expected bytes are queued at drive time.
  task automatic send_num(input logic [31:0] n, input logic [95:0] s, input int unsigned len);
    int unsigned cyc;
    cyc = 0;
    while (!n_rdy && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!n_rdy) begin
      checks++; errors++;
      $display("FAIL n_rdy_timeout: got 0 expected 1");
    end else begin
      push_str(s, len);
      n_dtm = n;
      n_vld = 1'b1;
      @(posedge clk); #1;
      n_vld = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int unsigned cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || !n_rdy) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_n_rdy", {31'd0, n_rdy}, 1);
  endtask

  // Downstream ready: always 1 unless random stalls are enabled.
  initial begin
    s_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      s_rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_hold_vld", {31'd0, s_vld}, 1);
          chk("stall_hold_dtm", {24'd0, s_dtm}, {24'd0, prev_dtm});
        end
        if (s_vld && s_rdy) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte: got %02h expected none", s_dtm);
          end else begin
            chk("byte", {24'd0, s_dtm}, {24'd0, exp_q.pop_front()});
          end
        end
        prev_stall = s_vld && !s_rdy;
        prev_dtm   = s_dtm;
      end
    end
  end

  initial begin
    int unsigned cyc;
    int unsigned calc_cycles;
    int base;
    logic bad;

`ifdef NUM_TO_STR_SIGNED_EN
    vecs[0] = '{32'd5,          96'("5"),           1};
    vecs[1] = '{32'h80000000,   96'("-2147483648"), 11};
    vecs[2] = '{32'hFFFFFFFF,   96'("-1"),          2};
    vecs[3] = '{32'hFFFFFF85,   96'("-123"),        4};
    vecs[4] = '{32'd2147483647, 96'("2147483647"),  10};
    vecs[5] = '{32'd0,          96'("0"),           1};
`else
    vecs[0] = '{32'd4294967295, 96'("4294967295"),  10};
    vecs[1] = '{32'd1000,       96'("1000"),        4};
    vecs[2] = '{32'd7,          96'("7"),           1};
    vecs[3] = '{32'd10,         96'("10"),          2};
    vecs[4] = '{32'd100000,     96'("100000"),      6};
    vecs[5] = '{32'd987654321,  96'("987654321"),   9};
    vecs[6] = '{32'hFFFFFFFF,   96'("4294967295"),  10};
`endif

    rst_n = 1'b0;
    n_vld = 1'b0;
    n_dtm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_vld", {31'd0, s_vld}, 0);
    chk("reset_n_rdy", {31'd0, n_rdy}, 1);
    chk("reset_s_dtm", {24'd0, s_dtm}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero: single "0" then terminator; n_rdy stays low through the terminator handshake.
    send_num(32'd0, 96'("0"), 1);
    bad = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      if (n_rdy) bad = 1'b1;
      if (s_vld && s_dtm == 8'h0A) break;
      cyc++;
    end
    chk("zero_n_rdy_low_until_term", {31'd0, bad}, 0);
    @(negedge clk);
    chk("zero_n_rdy_after_term", {31'd0, n_rdy}, 1);
    wait_drain();

    // Table vectors, offered back-to-back.
    for (int i = 0; i < NV; i++) send_num(vecs[i].n, vecs[i].s, vecs[i].len);
    wait_drain();

`ifndef NUM_TO_STR_SIGNED_EN
    // CALC cycles for 4294967295: digit sum 57 + one commit per digit (10).
    send_num(32'd4294967295, 96'("4294967295"), 10);
    calc_cycles = 0;
    cyc = 0;
    while (cyc < 500) begin
      @(negedge clk);
      if (n_rdy) break;
      if (!s_vld) calc_cycles++;
      cyc++;
    end
    chk("max_calc_cycles", calc_cycles, 67);
    wait_drain();
`endif

    // Random downstream stalls.
    stall_en = 1'b1;
    send_num(32'd305, 96'("305"), 3);
    wait_drain();
    stall_en = 1'b0;
    @(posedge clk); #1;

    // Reset after two digits of 12345: conversion abandoned, no terminator.
    base = hs_count;
    send_num(32'd12345, 96'("12345"), 5);
    cyc = 0;
    while (hs_count < base + 2 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("midreset_two_digits_seen", hs_count - base, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_s_vld", {31'd0, s_vld}, 0);
    chk("midreset_n_rdy", {31'd0, n_rdy}, 1);
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_num(32'd9, 96'("9"), 1);
    wait_drain();
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/num_to_str.md
NUM_TO_STR -- requirements
Module: num_to_str

Interface
REQ-001 SHALL have parameter: TERM_CHAR, 8'h0A, ASCII byte emitted after the last digit of every number.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: n_dtm  input  32  number to convert.
REQ-005 SHALL have port: n_vld  input  1  n_dtm valid.
REQ-006 SHALL have port: n_rdy  output  1  block can accept a number.
REQ-007 SHALL have port: s_dtm  output  8  ASCII character out.
REQ-008 SHALL have port: s_vld  output  1  s_dtm valid.
REQ-009 SHALL have port: s_rdy  input  1  downstream accepts s_dtm.

Function
REQ-010 SHALL capture n_dtm into the remainder register on the n_vld && n_rdy cycle and enter CALC with digit index 9 (10^9).
REQ-011 SHALL use states IDLE, CALC, SEND, TERM; n_rdy = (state == IDLE); s_vld = (state == SEND || state == TERM).
REQ-012 SHALL, per CALC cycle: if rem >= 10^idx, then rem -= 10^idx and digit++; else commit the digit.
REQ-013 SHALL, on commit: with digit == 0, no digit emitted yet, and idx != 0, skip the digit (idx--, digit = 0, stay in CALC); otherwise load s_dtm = 8'h30 + digit and enter SEND.
REQ-014 SHALL emit zeros after the first nonzero digit; input 0 SHALL emit the single character "0".
REQ-015 SHALL hold s_dtm and s_vld stable while s_vld && !s_rdy.
REQ-016 SHALL, on the SEND handshake: with idx != 0, idx--, digit = 0, return to CALC; with idx == 0, enter TERM with s_dtm = TERM_CHAR.
REQ-017 SHALL, on the TERM handshake, return to IDLE; n_rdy asserts the next cycle.
REQ-018 SHALL use a digit counter of 4 bits, never exceeding 9, and a remainder of 32 bits, unsigned, with no overflow possible.
REQ-019 SHALL have a latency of exactly d+1 CALC cycles for a digit of value d; a skipped leading zero SHALL cost 1 cycle.
REQ-020 SHALL ignore n_vld outside IDLE; no input SHALL be buffered.

Reset
REQ-021 SHALL, with rst_n low at a clock edge, set: state = IDLE, s_vld = 0, s_dtm = 8'h00, n_rdy = 1, rem = 0, idx = 9, digit = 0, started flag = 0.
REQ-022 SHALL, on reset mid-number, abandon the conversion with no terminator emitted; the first handshake after reset SHALL start a fresh number.

Configuration
REQ-023 SHALL, with NUM_TO_STR_SIGNED_EN defined, treat n_dtm as two's complement:
- negative input: emit "-" (8'h2D) via SEND first, then convert the 32-bit magnitude (0x80000000 gives 2147483648).
- non-negative input: behave as unsigned.
REQ-024 SHALL, with NUM_TO_STR_SIGNED_EN undefined, treat n_dtm as unsigned and never emit "-".

Structure
REQ-025 SHALL place the state enum, the ASCII constants ("0", "-") and the 10-entry power-of-ten table (10^0..10^9, 32-bit) in package num_to_str_pkg.
REQ-026 SHALL use one sub-module, num_to_str_pow10: combinational, 4-bit idx to 32-bit 10^idx.

Verification
REQ-027 SHALL cover: n_dtm=0, s_rdy=1 -> bytes 30 0A; n_rdy low until the 0A handshake.
REQ-028 SHALL cover: n_dtm=4294967295 -> "4294967295" then 0A; CALC cycle count equals digit sum + 10.
REQ-029 SHALL cover: n_dtm=1000, then n_dtm=7 back-to-back -> "1000\n7\n"; the internal zeros SHALL be emitted.
REQ-030 SHALL cover: n_dtm=305 with random s_rdy stalls -> "305\n"; s_dtm is stable on every stalled cycle.
REQ-031 SHALL cover, with NUM_TO_STR_SIGNED_EN defined: n_dtm=0x80000000 -> "-2147483648\n"; n_dtm=0xFFFFFFFF -> "-1\n".
REQ-032 SHALL cover: rst_n low after two digits of 12345 -> s_vld=0 and n_rdy=1; next n_dtm=9 -> "9\n".
